// File: rtl/pipeline_stage_sequencer_pkg.sv
// Shared constants for the pipeline stage sequencer.
// Stage and group values are bit indices: pipeline_stage and opcode_group
// are one-hot vectors of width STAGE_COUNT / GROUP_COUNT.
package pipeline_stage_sequencer_pkg;

   // stage indices into the one-hot pipeline_stage code
   localparam int STAGE_IF    = 0;
   localparam int STAGE_ID    = 1;
   localparam int STAGE_EX    = 2;
   localparam int STAGE_MEM   = 3;
   localparam int STAGE_WB    = 4;
   localparam int STAGE_IDLE  = 5;
   localparam int STAGE_COUNT = 6;

   // opcode group indices into the one-hot opcode_group vector
   localparam int GROUP_ALU    = 0;
   localparam int GROUP_LOAD   = 1;
   localparam int GROUP_STORE  = 2;
   localparam int GROUP_BRANCH = 3;
   localparam int GROUP_COUNT  = 4;

   // one-hot stage code for a stage index
   function automatic logic [STAGE_COUNT-1:0] stage_code(input int idx);
      logic [STAGE_COUNT-1:0] code;
      code      = '0;
      code[idx] = 1'b1;
      return code;
   endfunction

endpackage

// File: rtl/pipeline_stage_sequencer_counter.sv
// seq_perf_counter: free-running wrap-around counter with enable and
// synchronous active-high clear.
module seq_perf_counter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   output logic [WIDTH-1:0] count
);

   // count up when enabled, wrapping naturally at 2^WIDTH
   always_ff @(posedge clk) begin
      if (reset)   count <= '0;
      else if (en) count <= count + 1'b1;
   end

endmodule

// File: rtl/pipeline_stage_sequencer.sv
// pipeline_stage_sequencer: walks each instruction through IF(1/2), ID, EX,
// MEM, WB; stalls MEM on load/store until mem_ready; parks in IDLE on halt.
// Optional performance counters enabled by macro SEQ_PERF_COUNTERS_EN.
module pipeline_stage_sequencer
   import pipeline_stage_sequencer_pkg::*;
#(
   parameter int CNT_WIDTH = 32
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [GROUP_COUNT-1:0] opcode_group,
   input  logic                   instr_two_words,
   input  logic                   mem_ready,
   input  logic                   halt_req,
   output logic [STAGE_COUNT-1:0] pipeline_stage,
   output logic                   fetch_second_word,
   output logic                   pc_inc,
   output logic                   instr_retired,
`ifdef SEQ_PERF_COUNTERS_EN
   output logic [CNT_WIDTH-1:0]   cycle_count,
   output logic [CNT_WIDTH-1:0]   instr_count,
`endif
   output logic                   halted
);

   localparam logic [2:0] S_IF1  = 3'd0;
   localparam logic [2:0] S_IF2  = 3'd1;
   localparam logic [2:0] S_ID   = 3'd2;
   localparam logic [2:0] S_EX   = 3'd3;
   localparam logic [2:0] S_MEM  = 3'd4;
   localparam logic [2:0] S_WB   = 3'd5;
   localparam logic [2:0] S_IDLE = 3'd6;

   logic [2:0] state, state_nxt;
   logic       mem_op;

   assign mem_op = opcode_group[GROUP_LOAD] | opcode_group[GROUP_STORE];

   // state register; reset abandons any instruction in flight
   always_ff @(posedge clk) begin
      if (reset) state <= S_IF1;
      else       state <= state_nxt;
   end

   // next-state: halt only looked at in WB so the current instruction completes
   always_comb begin
      state_nxt = state;
      case (state)
         S_IF1:   state_nxt = instr_two_words ? S_IF2 : S_ID;
         S_IF2:   state_nxt = S_ID;
         S_ID:    state_nxt = S_EX;
         S_EX:    state_nxt = S_MEM;
         S_MEM:   state_nxt = (!mem_op || mem_ready) ? S_WB : S_MEM;
         S_WB:    state_nxt = halt_req ? S_IDLE : S_IF1;
         S_IDLE:  state_nxt = halt_req ? S_IDLE : S_IF1;
         default: state_nxt = S_IF1;
      endcase
   end

   // outputs decoded purely from the state register
   always_comb begin
      pipeline_stage    = stage_code(STAGE_IF);
      fetch_second_word = 1'b0;
      pc_inc            = 1'b0;
      instr_retired     = 1'b0;
      halted            = 1'b0;
      case (state)
         S_IF1:  pc_inc = 1'b1;
         S_IF2: begin
            pc_inc            = 1'b1;
            fetch_second_word = 1'b1;
         end
         S_ID:   pipeline_stage = stage_code(STAGE_ID);
         S_EX:   pipeline_stage = stage_code(STAGE_EX);
         S_MEM:  pipeline_stage = stage_code(STAGE_MEM);
         S_WB: begin
            pipeline_stage = stage_code(STAGE_WB);
            instr_retired  = 1'b1;
         end
         S_IDLE: begin
            pipeline_stage = stage_code(STAGE_IDLE);
            halted         = 1'b1;
         end
         default: pc_inc = 1'b1;
      endcase
   end

`ifdef SEQ_PERF_COUNTERS_EN
   seq_perf_counter #(.WIDTH(CNT_WIDTH)) u_cycle_cnt (
      .clk   (clk),
      .reset (reset),
      .en    (state != S_IDLE),
      .count (cycle_count)
   );

   seq_perf_counter #(.WIDTH(CNT_WIDTH)) u_instr_cnt (
      .clk   (clk),
      .reset (reset),
      .en    (instr_retired),
      .count (instr_count)
   );
`endif

endmodule
